// File: rtl/ts_latency_meter_if.sv
// ts_latency_meter_if: byte-wide AXI-Stream tap (no tready) observed by ts_latency_meter
interface ts_latency_meter_if;
  logic [7:0] tdata;
  logic tvalid;
  logic tlast;
  logic tuser;
  modport master (output tdata, tvalid, tlast, tuser);
  modport slave (input tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/ts_latency_meter.sv
// ts_latency_meter: passive stream monitor measuring one-way latency from an embedded 24-bit timestamp
// Define LATENCY_STATS_EN to add min/max latency tracking on lat_min/lat_max.
module ts_latency_meter #(
  parameter int TS_OFFSET = 14,
  parameter int ALARM_US = 1000,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [23:0]          timestamp,
  ts_latency_meter_if.slave    s_axis,
  input  logic                 stats_clear,
  output logic [23:0]          latency,
  output logic                 latency_valid,
  output logic                 short_frame,
  output logic                 late_alarm,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [23:0]          lat_min,
  output logic [23:0]          lat_max
);
  localparam int CW = $clog2(TS_OFFSET + 4);
  localparam logic [CW-1:0] PRE_TS = CW'(TS_OFFSET > 0 ? TS_OFFSET - 1 : 0);
  localparam logic [CW-1:0] LAST_TS = CW'(TS_OFFSET + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(TS_OFFSET + 3);
  localparam logic [23:0] ALARM = 24'(ALARM_US);
  typedef enum logic [1:0] {SKIP, CAPT, BODY} state_t;
  localparam state_t START = state_t'(TS_OFFSET == 0 ? CAPT : SKIP);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [23:0] ts, rx_ts, new_lat;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic beat, eof, done, meas, short_eof;
  assign beat = s_axis.tvalid;
  assign eof = beat & s_axis.tlast;
  // the third timestamp byte may itself be the tlast beat, so splice it in combinationally
  assign done = state == BODY || (state == CAPT && cnt == LAST_TS);
  assign rx_ts = state == BODY ? ts : {ts[15:0], s_axis.tdata};
  assign new_lat = timestamp - rx_ts;
  assign meas = eof & ~s_axis.tuser & done;
  assign short_eof = eof & ~s_axis.tuser & ~done;
  assign cnt_base = stats_clear ? '0 : frame_cnt;
  always_comb begin
    nxt = state;
    nxt = !beat ? state :
          s_axis.tlast ? START :
          state == SKIP && cnt == PRE_TS ? CAPT :
          state == CAPT && cnt == LAST_TS ? BODY : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= START;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ts <= '0;
      latency <= '0;
      latency_valid <= 1'b0;
      short_frame <= 1'b0;
      late_alarm <= 1'b0;
      frame_cnt <= '0;
    end else begin
      cnt <= eof ? '0 : beat && cnt != CNT_SAT ? cnt + 1'b1 : cnt;
      ts <= beat && state == CAPT ? {ts[15:0], s_axis.tdata} : ts;
      latency <= meas ? new_lat : latency;
      latency_valid <= meas;
      short_frame <= short_eof;
      late_alarm <= meas && new_lat > ALARM;
      frame_cnt <= cnt_base + CNT_WIDTH'(meas && cnt_base != '1);
    end
`ifdef LATENCY_STATS_EN
  logic [23:0] min_base, max_base;
  assign min_base = stats_clear ? 24'hFFFFFF : lat_min;
  assign max_base = stats_clear ? 24'h000000 : lat_max;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lat_min <= 24'hFFFFFF;
      lat_max <= 24'h000000;
    end else begin
      lat_min <= meas && new_lat < min_base ? new_lat : min_base;
      lat_max <= meas && new_lat > max_base ? new_lat : max_base;
    end
`else
  assign lat_min = 24'h0;
  assign lat_max = 24'h0;
`endif
endmodule
